// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU control decoder),
// default datapath width and the multi-cycle engine state encoding.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_NOP  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTI = 4'b1011;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} md_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the control side (master) and the execution ALU (slave).
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, alu_op, a, b,
        input  busy, done, result, zero, overflow, div_by_zero
    );

    modport slave (
        input  start, alu_op, a, b,
        output busy, done, result, zero, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] res,
    output logic             dbz
);
    localparam int unsigned CntW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;  // product accumulator or partial remainder
    logic [WIDTH-1:0] x_q, x_d;      // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0] y_q, y_d;      // multiplier, or divisor magnitude
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_sh, diff;
    logic             last;

    assign mag_a  = a[WIDTH-1] ? -a : a;
    assign mag_b  = b[WIDTH-1] ? -b : b;
    assign rem_sh = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, y_q};
    assign last   = (cnt_q == CntW'(WIDTH - 1));
    assign busy   = (state_q == StMul) || (state_q == StDiv);
    assign dbz    = (state_q == StDiv) && (y_q == '0);

    // The sign fix is applied on the final iteration edge so the corrected value is
    // already registered by the top when the engine sits in StFix.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        neg_d   = neg_q;
        ready   = 1'b0;
        res     = '0;
        unique case (state_q)
            StIdle, StFix: begin
                if (state_q == StFix) state_d = StIdle;
                if (go) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (is_div) begin
                        state_d = StDiv;
                        x_d     = mag_a;
                        y_d     = mag_b;
                        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        state_d = StMul;
                        x_d     = a;
                        y_d     = b;
                        neg_d   = 1'b0;
                    end
                end
            end
            StMul: begin
                if (y_q[0]) acc_d = acc_q + {1'b0, x_q};
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = StFix;
                    ready   = 1'b1;
                    res     = acc_d[WIDTH-1:0];
                end
            end
            StDiv: begin
                if (!diff[WIDTH]) begin
                    acc_d = diff;
                    x_d   = {x_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh;
                    x_d   = {x_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = StFix;
                    ready   = 1'b1;
                    res     = dbz ? '1 : (neg_q ? -x_d : x_d);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            neg_q   <= neg_d;
        end
    end
endmodule

// File: rtl/alu_exec.sv
// Execution ALU: single-cycle ops computed combinationally, MUL/DIV delegated to the
// iterative engine; all outputs registered and held between done pulses.
module alu_exec import alu_pkg::*; #(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input logic       clk,
    input logic       rst,
    alu_exec_if.slave bus
);
    logic             md_busy, md_ready, md_dbz;
    logic [WIDTH-1:0] md_res;
    logic             is_md, accept;
    logic [WIDTH-1:0] sum, dif, sc_res;
    logic             add_ovf, sub_ovf, sc_ovf, lt;

    logic [WIDTH-1:0] result_q;
    logic             done_q, zero_q, ovf_q, dbz_q;

    assign is_md  = (bus.alu_op == ALU_MUL) || (bus.alu_op == ALU_DIV);
    assign accept = bus.start && !md_busy;

    assign sum     = bus.a + bus.b;
    assign dif     = bus.a - bus.b;
    assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
    assign lt      = $signed(bus.a) < $signed(bus.b);

    // Unassigned codes 1100-1111 fall through to ADD.
    always_comb begin
        sc_res = sum;
        sc_ovf = add_ovf;
        case (bus.alu_op)
            ALU_SUB: begin
                sc_res = dif;
                sc_ovf = sub_ovf;
            end
            ALU_AND: begin sc_res = bus.a & bus.b;              sc_ovf = 1'b0; end
            ALU_OR:  begin sc_res = bus.a | bus.b;              sc_ovf = 1'b0; end
            ALU_NOR: begin sc_res = ~(bus.a | bus.b);           sc_ovf = 1'b0; end
            ALU_XOR: begin sc_res = bus.a ^ bus.b;              sc_ovf = 1'b0; end
            ALU_SRL: begin sc_res = bus.a >> bus.b[4:0];        sc_ovf = 1'b0; end
            ALU_SLT, ALU_SLTI: begin
                sc_res = {{(WIDTH-1){1'b0}}, lt};
                sc_ovf = 1'b0;
            end
            ALU_NOP, ALU_MUL, ALU_DIV: begin sc_res = '0;       sc_ovf = 1'b0; end
            default: ;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go     (accept && is_md),
        .is_div (bus.alu_op == ALU_DIV),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (md_busy),
        .ready  (md_ready),
        .res    (md_res),
        .dbz    (md_dbz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && !is_md) begin
                result_q <= sc_res;
                zero_q   <= (sc_res == '0);
                ovf_q    <= sc_ovf;
                dbz_q    <= 1'b0;
                done_q   <= 1'b1;
            end else if (md_ready) begin
                result_q <= md_res;
                zero_q   <= (md_res == '0);
                ovf_q    <= 1'b0;
                dbz_q    <= md_dbz;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.busy        = md_busy;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases, random ops against an arithmetic
// reference model, busy-ignore, reset-abort and back-to-back starts.
module tb_alu_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
        logic        d;
    } vec_t;

    // Reference model straight from the arithmetic rules, using wide signed integers.
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic o, output logic d,
                                  output int lat);
        longint sx, sy, s;
        sx = $signed(x);
        sy = $signed(y);
        o = 1'b0;
        d = 1'b0;
        lat = 1;
        case (op)
            4'd1: begin s = sx - sy; r = 32'(s); o = (longint'($signed(r)) != s); end
            4'd2: begin r = x * y; lat = 33; end
            4'd3: begin
                lat = 33;
                if (y == 32'd0) begin r = 32'hFFFF_FFFF; d = 1'b1; end
                else r = 32'(sx / sy);
            end
            4'd4: r = x & y;
            4'd5: r = x | y;
            4'd6: r = ~(x | y);
            4'd7: r = 32'd0;
            4'd8: r = x >> y[4:0];
            4'd9, 4'd11: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd10: r = x ^ y;
            default: begin s = sx + sy; r = 32'(s); o = (longint'($signed(r)) != s); end
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt, output logic [31:0] r,
                          output logic z, output logic o, output logic d);
        @(negedge clk);
        bus.alu_op = op;
        bus.a      = x;
        bus.b      = y;
        bus.start  = 1'b1;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) bcnt++;
        end while (!bus.done && lat < 40);
        r = bus.result;
        z = bus.zero;
        o = bus.overflow;
        d = bus.div_by_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.alu_op = 4'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.div_by_zero} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h zero=%b ovf=%b dbz=%b, want all 0",
                     bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.div_by_zero);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b done=%b result=%h, want 0",
                     bus.busy, bus.done, bus.result);
        end
    endtask

    task automatic test_directed();
        vec_t v [13];
        int lat, bcnt, elat;
        logic [31:0] r;
        logic z, o, d;
        v[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
        v[1]  = '{4'h2, 32'd12345,     32'd6789,      32'h04FE_D79D, 1'b0, 1'b0};
        v[2]  = '{4'h3, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 1'b0};
        v[3]  = '{4'h3, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1};
        v[4]  = '{4'h9, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 1'b0};
        v[5]  = '{4'h8, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 1'b0};
        v[6]  = '{4'h7, 32'h1234,      32'h5678,      32'h0000_0000, 1'b0, 1'b0};
        v[7]  = '{4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0};
        v[8]  = '{4'h1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0};
        v[9]  = '{4'hA, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0};
        v[10] = '{4'h6, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
        v[11] = '{4'hB, 32'd5,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        v[12] = '{4'hF, 32'd1,         32'd2,         32'h0000_0003, 1'b0, 1'b0};
        foreach (v[i]) begin
            elat = (v[i].op == 4'h2 || v[i].op == 4'h3) ? 33 : 1;
            run_op(v[i].op, v[i].a, v[i].b, lat, bcnt, r, z, o, d);
            n_checks++;
            if ({lat, bcnt, r, z, o, d} !== {elat, (elat == 33) ? 32 : 0, v[i].r, v[i].r == 32'd0,
                                              v[i].o, v[i].d}) begin
                n_fail++;
                $display("FAIL directed[%0d] op=%h: lat=%0d busy=%0d r=%h z=%b o=%b d=%b, want lat=%0d r=%h o=%b d=%b",
                         i, v[i].op, lat, bcnt, r, z, o, d, elat, v[i].r, v[i].o, v[i].d);
            end
            @(negedge clk);
            n_checks++;
            if ({bus.done, bus.result} !== {1'b0, v[i].r}) begin
                n_fail++;
                $display("FAIL hold[%0d]: done=%b result=%h, want done=0 result=%h",
                         i, bus.done, bus.result, v[i].r);
            end
        end
    endtask

    task automatic test_random();
        int lat, bcnt, elat;
        logic [31:0] x, y, r, er;
        logic [3:0] op;
        logic z, o, d, eo, ed;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: x = 32'h7FFF_FFFF;
                default: ;
            endcase
            model(op, x, y, er, eo, ed, elat);
            run_op(op, x, y, lat, bcnt, r, z, o, d);
            n_checks++;
            if ({lat, bcnt, r, z, o, d} !== {elat, (elat == 33) ? 32 : 0, er, er == 32'd0, eo, ed}) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h a=%h b=%h: lat=%0d busy=%0d r=%h z=%b o=%b d=%b, want lat=%0d r=%h o=%b d=%b",
                         i, op, x, y, lat, bcnt, r, z, o, d, elat, er, eo, ed);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int first = 0, ndone = 0;
        logic [31:0] r = 32'd0;
        @(negedge clk);
        bus.alu_op = 4'h2; bus.a = 32'd1000; bus.b = 32'd3000; bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (first == 0) begin first = c; r = bus.result; end
            end
            if (c == 5) begin
                bus.alu_op = 4'h0; bus.a = 32'd11; bus.b = 32'd22; bus.start = 1'b1;
            end
            if (c == 6) bus.start = 1'b0;
        end
        n_checks++;
        if ({first, ndone, r} !== {33, 1, 32'd3000000}) begin
            n_fail++;
            $display("FAIL busy_ignore: first_done=%0d dones=%0d result=%h, want 33 1 %h",
                     first, ndone, r, 32'd3000000);
        end
    endtask

    task automatic test_reset_abort();
        int ndone = 0, lat, bcnt;
        logic [31:0] r;
        logic z, o, d;
        @(negedge clk);
        bus.alu_op = 4'h2; bus.a = 32'd77; bus.b = 32'd99; bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done) ndone++;
            if (c == 10) rst = 1'b1;
            if (c == 11) begin
                n_checks++;
                if ({bus.busy, bus.done, bus.result, bus.zero} !== 35'd0) begin
                    n_fail++;
                    $display("FAIL reset_abort_state: busy=%b done=%b result=%h zero=%b, want 0",
                             bus.busy, bus.done, bus.result, bus.zero);
                end
                rst = 1'b0;
            end
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL reset_abort_done: dones=%0d, want 0", ndone);
        end
        run_op(4'h0, 32'd3, 32'd4, lat, bcnt, r, z, o, d);
        n_checks++;
        if ({lat, r, z, o} !== {1, 32'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_abort_after: lat=%0d r=%h z=%b o=%b, want 1 7 0 0", lat, r, z, o);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, elat;
        logic [31:0] r, x, y, er;
        logic [3:0] op;
        logic z, o, d, eo, ed;
        logic [3:0] ops [6];
        ops = '{4'h0, 4'h1, 4'h4, 4'hA, 4'h9, 4'h8};
        run_op(4'h2, 32'hFFFF_FFFD, 32'd5, lat, bcnt, r, z, o, d);
        n_checks++;
        if ({lat, r} !== {33, 32'hFFFF_FFF1}) begin
            n_fail++;
            $display("FAIL b2b_mul: lat=%0d r=%h, want 33 fffffff1", lat, r);
        end
        // Each new start is issued in the cycle where the previous done is high.
        for (int i = 0; i < 6; i++) begin
            op = ops[i];
            x  = $urandom;
            y  = $urandom;
            model(op, x, y, er, eo, ed, elat);
            bus.alu_op = op; bus.a = x; bus.b = y; bus.start = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({bus.done, bus.result, bus.overflow} !== {1'b1, er, eo}) begin
                n_fail++;
                $display("FAIL b2b[%0d] op=%h: done=%b r=%h o=%b, want done=1 r=%h o=%b",
                         i, op, bus.done, bus.result, bus.overflow, er, eo);
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
